// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the 5-stage pipeline and hazard_stall_unit.
// master = pipeline side (hazard sources), slave = the stall/flush controller.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    // ID-stage instruction
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_uses_rs1;
    logic             ifid_uses_rs2;
    logic             ifid_is_store;
    // EX-stage instruction and branch resolution
    logic [4:0]       idex_rd;
    logic             idex_mem_to_reg;
    logic             branch_taken;
    // MEM-stage data memory handshake
    logic             dmem_req;
    logic             dmem_ready;
    // Stage controls
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    // Status and performance
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mem_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, ifid_is_store,
        output idex_rd, idex_mem_to_reg, branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  state, mem_timeout, lu_cnt, mem_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, ifid_is_store,
        input  idex_rd, idex_mem_to_reg, branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output state, mem_timeout, lu_cnt, mem_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV64 pipeline: load-use, data-memory wait, branch squash.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    // Must match the CNT_W of the connected interface instance.
    parameter int unsigned CNT_W       = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    hazard_stall_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2,
        StFlush   = 2'd3
    } state_e;

    // MEM_TIMEOUT larger than the counter range is truncated to CNT_W bits.
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic             mem_wait;
    logic             hit1, hit2;
    logic             lu_hazard;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             timeout_q, timeout_d;

    assign mem_wait  = bus.dmem_req & ~bus.dmem_ready;
    assign hit1      = bus.ifid_uses_rs1 & (bus.ifid_rs1 == bus.idex_rd);
    // Store data is bypassed in MEM, so an rs2-only dependency of a store never stalls.
    assign hit2      = bus.ifid_uses_rs2 & (bus.ifid_rs2 == bus.idex_rd) & ~bus.ifid_is_store;
    assign lu_hazard = bus.idex_mem_to_reg & (bus.idex_rd != 5'd0) & (hit1 | hit2);

    // Cause of the current cycle, highest priority first.
    always_comb begin
        state_d = StRun;
        if (mem_wait) begin
            state_d = StMemWait;
        end else if (bus.branch_taken) begin
            state_d = StFlush;
        end else if (lu_hazard) begin
            state_d = StLuStall;
        end
    end

    // Stage controls are combinational from the current cause.
    always_comb begin
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        if (i_rst) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_en    = 1'b0;
            bus.exmem_en   = 1'b0;
            bus.memwb_en   = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            unique case (state_d)
                StMemWait: begin
                    // Freeze everything, MEM/WB included, so forwarding sources hold still.
                    bus.pc_en    = 1'b0;
                    bus.ifid_en  = 1'b0;
                    bus.idex_en  = 1'b0;
                    bus.exmem_en = 1'b0;
                    bus.memwb_en = 1'b0;
                end
                StFlush: begin
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end
                StLuStall: begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Watchdog saturates at the threshold; the sticky flag holds until reset.
    always_comb begin
        wd_d = '0;
        if (mem_wait) begin
            wd_d = (wd_q == TimeoutVal) ? wd_q : wd_q + CntOne;
        end
        timeout_d = timeout_q | (mem_wait & (wd_d == TimeoutVal));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StRun;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

    // Saturating cycle counters per stall cause.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lu_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_d == StLuStall) && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + CntOne;
            end
            if ((state_d == StMemWait) && (mem_cnt_q != '1)) begin
                mem_cnt_q <= mem_cnt_q + CntOne;
            end
            if ((state_d == StFlush) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign bus.lu_cnt    = lu_cnt_q;
    assign bus.mem_cnt   = mem_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.lu_cnt    = '0;
    assign bus.mem_cnt   = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule
